// File: rtl/bisr_pkg.sv
// rtl/bisr_pkg.sv - shared constants and state type for the BISR repair allocator
//
// Contents:
//   SPARE_NUM_DEF / ADDR_W_DEF  default spare count and address width
//   ST_IDLE / ST_COLLECT / ST_LOCK  one-hot state encodings
//   bisr_state_e                FSM state type built on those encodings
package bisr_pkg;

    localparam int SPARE_NUM_DEF = 8;
    localparam int ADDR_W_DEF    = 16;

    localparam logic [2:0] ST_IDLE    = 3'b001;
    localparam logic [2:0] ST_COLLECT = 3'b010;
    localparam logic [2:0] ST_LOCK    = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_COLLECT = ST_COLLECT,
        S_LOCK    = ST_LOCK
    } bisr_state_e;

endpackage

// File: rtl/bisr_cam.sv
// rtl/bisr_cam.sv - spare-entry table with dedup and lookup match ports
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valid bits)
//   clr_i           clear all valid bits (start of a new BIST run)
//   wr_en_i         write wr_addr_i into entry wr_idx_i and mark it valid
//   wr_idx_i        entry index to write
//   wr_addr_i       address stored on write
//   cap_addr_i      capture-side address; cap_hit_o when it matches a valid entry
//   lkup_addr_i     lookup-side address; lkup_hit_o / lkup_idx_o give the lowest matching entry
module bisr_cam
    import bisr_pkg::*;
#(
    parameter int SPARE_NUM = SPARE_NUM_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int IDX_W     = $clog2(SPARE_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [ADDR_W-1:0] cap_addr_i,
    output logic              cap_hit_o,
    input  logic [ADDR_W-1:0] lkup_addr_i,
    output logic              lkup_hit_o,
    output logic [IDX_W-1:0]  lkup_idx_o
);

    logic [ADDR_W-1:0]    entry_q [SPARE_NUM];
    logic [SPARE_NUM-1:0] valid_q;
    logic [SPARE_NUM-1:0] cap_match;
    logic [SPARE_NUM-1:0] lkup_match;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Entry data needs no reset: an entry is only observable once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            entry_q[wr_idx_i] <= wr_addr_i;
        end
    end

    always_comb begin
        cap_match  = '0;
        lkup_match = '0;
        for (int i = 0; i < SPARE_NUM; i++) begin
            cap_match[i]  = valid_q[i] && (entry_q[i] == cap_addr_i);
            lkup_match[i] = valid_q[i] && (entry_q[i] == lkup_addr_i);
        end
    end

    assign cap_hit_o  = |cap_match;
    assign lkup_hit_o = |lkup_match;

    // Scan downward so the lowest matching index is the last assignment and wins.
    always_comb begin
        lkup_idx_o = '0;
        for (int i = SPARE_NUM - 1; i >= 0; i--) begin
            if (lkup_match[i]) begin
                lkup_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bisr_repair_alloc.sv
// rtl/bisr_repair_alloc.sv - BIST fault capture into spare entries and post-run remap lookup
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   BIST_EN       BIST run active (level)
//   FAIL_VALID    one-cycle fail strobe qualifying FAIL_ADDR
//   FAIL_ADDR     failing address to capture
//   LKUP_ADDR     normal-mode access address to check against the frozen table
//   REMAP_HIT     registered lookup hit (only when the table is locked)
//   REMAP_IDX     registered matching spare index, 0 on miss
//   REPAIR_CNT    number of valid entries
//   REPAIR_FULL   every spare is used
//   REPAIR_FAIL   sticky: a unique fault arrived with no spare left
//   REPAIR_DONE   table is locked and valid for lookup
module bisr_repair_alloc
    import bisr_pkg::*;
#(
    parameter int SPARE_NUM = SPARE_NUM_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int IDX_W     = $clog2(SPARE_NUM)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BIST_EN,
    input  logic              FAIL_VALID,
    input  logic [ADDR_W-1:0] FAIL_ADDR,
    input  logic [ADDR_W-1:0] LKUP_ADDR,
    output logic              REMAP_HIT,
    output logic [IDX_W-1:0]  REMAP_IDX,
    output logic [IDX_W:0]    REPAIR_CNT,
    output logic              REPAIR_FULL,
    output logic              REPAIR_FAIL,
    output logic              REPAIR_DONE
);

    localparam logic [IDX_W:0] SPARE_MAX = (IDX_W + 1)'(SPARE_NUM);

    bisr_state_e      state_q, state_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             fail_q, fail_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             tbl_clr;
    logic             cap_en;
    logic             wr_en;
    logic             cap_hit;
    logic             lkup_hit;
    logic [IDX_W-1:0] lkup_idx;

    bisr_cam #(
        .SPARE_NUM (SPARE_NUM),
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W)
    ) u_cam (
        .clk         (CLK),
        .rst         (RST),
        .clr_i       (tbl_clr),
        .wr_en_i     (wr_en),
        .wr_idx_i    (cnt_q[IDX_W-1:0]),
        .wr_addr_i   (FAIL_ADDR),
        .cap_addr_i  (FAIL_ADDR),
        .cap_hit_o   (cap_hit),
        .lkup_addr_i (LKUP_ADDR),
        .lkup_hit_o  (lkup_hit),
        .lkup_idx_o  (lkup_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Entering COLLECT from either IDLE or LOCK starts a fresh run, so the table is cleared
    // on that edge. Capture stays enabled through the cycle BIST_EN drops.
    always_comb begin
        state_d = state_q;
        tbl_clr = 1'b0;
        cap_en  = 1'b0;
        case (state_q)
            S_IDLE, S_LOCK: begin
                if (BIST_EN) begin
                    state_d = S_COLLECT;
                    tbl_clr = 1'b1;
                end
            end
            S_COLLECT: begin
                cap_en = FAIL_VALID;
                if (!BIST_EN) begin
                    state_d = S_LOCK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Dedup uses the pre-edge table, so a repeat on the very next cycle is already visible.
    always_comb begin
        cnt_d  = cnt_q;
        fail_d = fail_q;
        wr_en  = 1'b0;
        if (tbl_clr) begin
            cnt_d  = '0;
            fail_d = 1'b0;
        end else if (cap_en && !cap_hit) begin
            if (cnt_q < SPARE_MAX) begin
                wr_en = 1'b1;
                cnt_d = cnt_q + (IDX_W + 1)'(1);
            end else begin
                fail_d = 1'b1;
            end
        end
        full_d = (cnt_d == SPARE_MAX);
        hit_d  = (state_q == S_LOCK) && lkup_hit;
        idx_d  = hit_d ? lkup_idx : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            full_q <= 1'b0;
            fail_q <= 1'b0;
            hit_q  <= 1'b0;
            idx_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            full_q <= full_d;
            fail_q <= fail_d;
            hit_q  <= hit_d;
            idx_q  <= idx_d;
        end
    end

    assign REMAP_HIT   = hit_q;
    assign REMAP_IDX   = idx_q;
    assign REPAIR_CNT  = cnt_q;
    assign REPAIR_FULL = full_q;
    assign REPAIR_FAIL = fail_q;
    assign REPAIR_DONE = (state_q == S_LOCK);

endmodule

// File: tb/tb_bisr_repair_alloc.sv
// tb/tb_bisr_repair_alloc.sv - self-checking bench for bisr_repair_alloc
module tb_bisr_repair_alloc;

    localparam int SN = 8;
    localparam int AW = 16;
    localparam int IW = 3;

    logic          CLK = 1'b0;
    logic          RST;
    logic          BIST_EN;
    logic          FAIL_VALID;
    logic [AW-1:0] FAIL_ADDR;
    logic [AW-1:0] LKUP_ADDR;
    logic          REMAP_HIT;
    logic [IW-1:0] REMAP_IDX;
    logic [IW:0]   REPAIR_CNT;
    logic          REPAIR_FULL;
    logic          REPAIR_FAIL;
    logic          REPAIR_DONE;

    int n_vec = 0;
    int n_err = 0;

    // Model: mode 0 = idle, 1 = collecting, 2 = locked; table is an ordered list of unique faults.
    int            m_mode = 0;
    logic [AW-1:0] m_tab[$];
    bit            m_fail = 0;
    bit            m_hit  = 0;
    int            m_idx  = 0;

    bisr_repair_alloc #(.SPARE_NUM(SN), .ADDR_W(AW), .IDX_W(IW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BIST_EN     (BIST_EN),
        .FAIL_VALID  (FAIL_VALID),
        .FAIL_ADDR   (FAIL_ADDR),
        .LKUP_ADDR   (LKUP_ADDR),
        .REMAP_HIT   (REMAP_HIT),
        .REMAP_IDX   (REMAP_IDX),
        .REPAIR_CNT  (REPAIR_CNT),
        .REPAIR_FULL (REPAIR_FULL),
        .REPAIR_FAIL (REPAIR_FAIL),
        .REPAIR_DONE (REPAIR_DONE)
    );

    always #5 CLK = ~CLK;

    function automatic int m_find(input logic [AW-1:0] a);
        foreach (m_tab[i]) if (m_tab[i] == a) return i;
        return -1;
    endfunction

    // Apply one cycle of inputs, advance the model by the same edge, sample 1 ns later.
    task automatic step(input bit rst, input bit bist, input bit fv,
                        input logic [AW-1:0] fa, input logic [AW-1:0] la);
        int p;
        RST = rst; BIST_EN = bist; FAIL_VALID = fv; FAIL_ADDR = fa; LKUP_ADDR = la;
        @(posedge CLK);
        if (rst) begin
            m_mode = 0; m_tab.delete(); m_fail = 0; m_hit = 0; m_idx = 0;
        end else begin
            p = m_find(la);
            m_hit = (m_mode == 2) && (p >= 0);
            m_idx = m_hit ? p : 0;
            if (m_mode == 1 && fv && m_find(fa) < 0) begin
                if (m_tab.size() < SN) m_tab.push_back(fa);
                else m_fail = 1;
            end
            if (m_mode != 1 && bist) begin
                m_tab.delete(); m_fail = 0; m_mode = 1;
            end else if (m_mode == 1 && !bist) begin
                m_mode = 2;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 16'h0, 16'h0);
        step(1, 0, 0, 16'h0, 16'h0);
        n_vec++; if ({REMAP_HIT, REMAP_IDX, REPAIR_CNT} !== '0) begin n_err++; $display("FAIL reset_remap_cnt: got hit=%b idx=%0d cnt=%0d, want all 0", REMAP_HIT, REMAP_IDX, REPAIR_CNT); end
        n_vec++; if ({REPAIR_FULL, REPAIR_FAIL, REPAIR_DONE} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got full=%b fail=%b done=%b, want 000", REPAIR_FULL, REPAIR_FAIL, REPAIR_DONE); end
    endtask

    task automatic test_basic();
        step(0, 1, 0, 16'h0, 16'h0);
        step(0, 1, 1, 16'h0403, 16'h0);
        step(0, 1, 1, 16'h1C00, 16'h0);
        step(0, 1, 1, 16'h0403, 16'h0);
        n_vec++; if (REPAIR_DONE !== 1'b0) begin n_err++; $display("FAIL basic_done_collect: got %b want 0", REPAIR_DONE); end
        step(0, 0, 0, 16'h0, 16'h0);
        n_vec++; if (REPAIR_CNT !== 4'd2) begin n_err++; $display("FAIL basic_cnt: got %0d want 2", REPAIR_CNT); end
        n_vec++; if (REPAIR_DONE !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", REPAIR_DONE); end
        n_vec++; if ({REPAIR_FAIL, REPAIR_FULL} !== 2'b00) begin n_err++; $display("FAIL basic_flags: got fail=%b full=%b want 00", REPAIR_FAIL, REPAIR_FULL); end
    endtask

    task automatic test_lookup();
        step(0, 0, 0, 16'h0, 16'h1C00);
        n_vec++; if ({REMAP_HIT, REMAP_IDX} !== {1'b1, 3'd1}) begin n_err++; $display("FAIL lkup_1c00: got hit=%b idx=%0d want hit=1 idx=1", REMAP_HIT, REMAP_IDX); end
        step(0, 0, 0, 16'h0, 16'h1C01);
        n_vec++; if ({REMAP_HIT, REMAP_IDX} !== {1'b0, 3'd0}) begin n_err++; $display("FAIL lkup_1c01: got hit=%b idx=%0d want hit=0 idx=0", REMAP_HIT, REMAP_IDX); end
        step(0, 0, 0, 16'h0, 16'h0403);
        n_vec++; if ({REMAP_HIT, REMAP_IDX} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL lkup_0403: got hit=%b idx=%0d want hit=1 idx=0", REMAP_HIT, REMAP_IDX); end
    endtask

    task automatic test_ignore();
        step(0, 0, 1, 16'h7777, 16'h0);
        n_vec++; if (REPAIR_CNT !== 4'd2) begin n_err++; $display("FAIL ignore_lock_cnt: got %0d want 2", REPAIR_CNT); end
        step(0, 0, 0, 16'h0, 16'h7777);
        n_vec++; if (REMAP_HIT !== 1'b0) begin n_err++; $display("FAIL ignore_lock_hit: got %b want 0", REMAP_HIT); end
        step(1, 0, 0, 16'h0, 16'h0);
        step(0, 0, 1, 16'h5555, 16'h0);
        n_vec++; if ({REPAIR_CNT, REPAIR_DONE} !== 5'b0) begin n_err++; $display("FAIL ignore_idle: got cnt=%0d done=%b want 0 0", REPAIR_CNT, REPAIR_DONE); end
        step(0, 1, 0, 16'h0, 16'h0);
        step(0, 1, 1, 16'h1234, 16'h0);
        step(0, 1, 0, 16'h0, 16'h1234);
        n_vec++; if ({REMAP_HIT, REPAIR_CNT} !== {1'b0, 4'd1}) begin n_err++; $display("FAIL collect_lookup: got hit=%b cnt=%0d want hit=0 cnt=1", REMAP_HIT, REPAIR_CNT); end
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h1234);
        n_vec++; if ({REMAP_HIT, REMAP_IDX} !== {1'b1, 3'd0}) begin n_err++; $display("FAIL lock_lookup_1234: got hit=%b idx=%0d want hit=1 idx=0", REMAP_HIT, REMAP_IDX); end
    endtask

    task automatic test_overflow();
        logic [AW-1:0] a;
        step(1, 0, 0, 16'h0, 16'h0);
        step(0, 1, 0, 16'h0, 16'h0);
        for (int i = 0; i < 9; i++) begin
            a = 16'h0100 + 16'(i);
            step(0, 1, 1, a, 16'h0);
            if (i == 6) begin
                n_vec++; if ({REPAIR_CNT, REPAIR_FULL} !== {4'd7, 1'b0}) begin n_err++; $display("FAIL ovf_7th: got cnt=%0d full=%b want 7 0", REPAIR_CNT, REPAIR_FULL); end
            end
            if (i == 7) begin
                n_vec++; if ({REPAIR_CNT, REPAIR_FULL, REPAIR_FAIL} !== {4'd8, 1'b1, 1'b0}) begin n_err++; $display("FAIL ovf_8th: got cnt=%0d full=%b fail=%b want 8 1 0", REPAIR_CNT, REPAIR_FULL, REPAIR_FAIL); end
            end
        end
        n_vec++; if ({REPAIR_CNT, REPAIR_FULL, REPAIR_FAIL} !== {4'd8, 1'b1, 1'b1}) begin n_err++; $display("FAIL ovf_9th: got cnt=%0d full=%b fail=%b want 8 1 1", REPAIR_CNT, REPAIR_FULL, REPAIR_FAIL); end
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0108);
        n_vec++; if (REMAP_HIT !== 1'b0) begin n_err++; $display("FAIL ovf_lkup_9th: got hit=%b want 0", REMAP_HIT); end
        step(0, 0, 0, 16'h0, 16'h0107);
        n_vec++; if ({REMAP_HIT, REMAP_IDX} !== {1'b1, 3'd7}) begin n_err++; $display("FAIL ovf_lkup_8th: got hit=%b idx=%0d want hit=1 idx=7", REMAP_HIT, REMAP_IDX); end
    endtask

    task automatic test_rerun();
        step(0, 1, 0, 16'h0, 16'h0100);
        n_vec++; if ({REPAIR_CNT, REPAIR_FULL, REPAIR_FAIL, REPAIR_DONE} !== 7'b0) begin n_err++; $display("FAIL rerun_clear: got cnt=%0d full=%b fail=%b done=%b want all 0", REPAIR_CNT, REPAIR_FULL, REPAIR_FAIL, REPAIR_DONE); end
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0100);
        n_vec++; if ({REMAP_HIT, REPAIR_DONE} !== 2'b01) begin n_err++; $display("FAIL rerun_old_miss: got hit=%b done=%b want hit=0 done=1", REMAP_HIT, REPAIR_DONE); end
    endtask

    task automatic test_mid_reset();
        step(0, 1, 0, 16'h0, 16'h0);
        step(0, 1, 1, 16'h0A00, 16'h0);
        step(0, 1, 1, 16'h0A00, 16'h0);
        n_vec++; if (REPAIR_CNT !== 4'd1) begin n_err++; $display("FAIL dedup_next_cycle: got cnt=%0d want 1", REPAIR_CNT); end
        step(0, 1, 1, 16'h0A01, 16'h0);
        step(0, 1, 1, 16'hFC00, 16'h0);
        n_vec++; if (REPAIR_CNT !== 4'd3) begin n_err++; $display("FAIL mid_cnt3: got cnt=%0d want 3", REPAIR_CNT); end
        step(1, 1, 0, 16'h0, 16'h0);
        n_vec++; if ({REMAP_HIT, REMAP_IDX, REPAIR_CNT, REPAIR_FULL, REPAIR_FAIL, REPAIR_DONE} !== '0) begin n_err++; $display("FAIL mid_reset_outs: got cnt=%0d done=%b hit=%b want all 0", REPAIR_CNT, REPAIR_DONE, REMAP_HIT); end
        step(0, 1, 0, 16'h0, 16'h0);
        step(0, 1, 1, 16'hABCD, 16'h0);
        step(0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 0, 16'h0, 16'hABCD);
        n_vec++; if ({REMAP_HIT, REMAP_IDX, REPAIR_CNT} !== {1'b1, 3'd0, 4'd1}) begin n_err++; $display("FAIL refill_entry0: got hit=%b idx=%0d cnt=%0d want 1 0 1", REMAP_HIT, REMAP_IDX, REPAIR_CNT); end
        step(0, 0, 0, 16'h0, 16'h0A00);
        n_vec++; if (REMAP_HIT !== 1'b0) begin n_err++; $display("FAIL refill_old_miss: got hit=%b want 0", REMAP_HIT); end
    endtask

    task automatic test_random();
        logic [AW-1:0] pool[12];
        bit bist;
        bit rst;
        foreach (pool[i]) pool[i] = AW'($urandom);
        bist = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(14) == 0) bist = ~bist;
            rst = ($urandom_range(199) == 0);
            step(rst, bist, 1'($urandom_range(1)), pool[$urandom_range(11)],
                 ($urandom_range(7) == 0) ? AW'($urandom) : pool[$urandom_range(11)]);
            n_vec++; if (REPAIR_CNT !== (IW + 1)'(m_tab.size())) begin n_err++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, REPAIR_CNT, m_tab.size()); end
            n_vec++; if (REPAIR_FULL !== (m_tab.size() == SN)) begin n_err++; $display("FAIL rnd_full c=%0d: got %b want %b", c, REPAIR_FULL, m_tab.size() == SN); end
            n_vec++; if (REPAIR_FAIL !== m_fail) begin n_err++; $display("FAIL rnd_fail c=%0d: got %b want %b", c, REPAIR_FAIL, m_fail); end
            n_vec++; if (REPAIR_DONE !== (m_mode == 2)) begin n_err++; $display("FAIL rnd_done c=%0d: got %b want %b", c, REPAIR_DONE, m_mode == 2); end
            n_vec++; if (REMAP_HIT !== m_hit) begin n_err++; $display("FAIL rnd_hit c=%0d: got %b want %b", c, REMAP_HIT, m_hit); end
            n_vec++; if (REMAP_IDX !== IW'(m_idx)) begin n_err++; $display("FAIL rnd_idx c=%0d: got %0d want %0d", c, REMAP_IDX, m_idx); end
        end
    endtask

    initial begin
        RST = 1'b1; BIST_EN = 1'b0; FAIL_VALID = 1'b0; FAIL_ADDR = '0; LKUP_ADDR = '0;
        test_reset();
        test_basic();
        test_lookup();
        test_ignore();
        test_overflow();
        test_rerun();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bisr_repair_alloc.md
# bisr_repair_alloc

Repair-allocation stage directly downstream of the BIST engine. During a BIST run it captures each reported failing 16-bit address into a small table of spare entries, discarding duplicates. After the run it freezes the table and answers address lookups from the memory controller's normal access path, so failing rows are steered to spare storage. It flags overflow when the faults outnumber the spares.

## Interface
- SPARE_NUM, 8: number of spare entries (2..32).
- ADDR_W, 16: fault/lookup address width; bits [15:10] are bank select, bits [9:0] are row.
- IDX_W, $clog2(SPARE_NUM): spare index width.

- CLK  in  1  single clock, all state on posedge.
- RST  in  1  synchronous, active-high reset.
- BIST_EN  in  1  BIST run active; level-sensitive.
- FAIL_VALID  in  1  one-cycle fail strobe from BIST (its fail flag).
- FAIL_ADDR  in  ADDR_W  failing address; qualified by FAIL_VALID.
- LKUP_ADDR  in  ADDR_W  normal-mode access address to check.
- REMAP_HIT  out  1  registered: LKUP_ADDR matches a stored fault.
- REMAP_IDX  out  IDX_W  registered: matching spare index (0 when no hit).
- REPAIR_CNT  out  IDX_W+1  number of valid entries.
- REPAIR_FULL  out  1  all SPARE_NUM entries used.
- REPAIR_FAIL  out  1  sticky: a unique fault arrived while full (unrepairable).
- REPAIR_DONE  out  1  high in LOCK state (table valid for lookup).

## Operation
- States: IDLE, COLLECT, LOCK (one-hot, 3 bits).
- IDLE: BIST_EN=1 -> COLLECT; the transition edge clears all valid bits, REPAIR_CNT=0, REPAIR_FAIL=0.
- COLLECT: BIST_EN=0 -> LOCK; otherwise stay.
- LOCK: BIST_EN=1 -> COLLECT with the same clear as from IDLE; otherwise stay.
- Capture, only while the state is COLLECT (including the cycle BIST_EN drops):
  - If FAIL_VALID=1 and FAIL_ADDR matches a valid entry, ignore it (dedup).
  - Else if REPAIR_CNT<SPARE_NUM, write FAIL_ADDR to entry[REPAIR_CNT] and set its valid bit; REPAIR_CNT increments.
  - Else set REPAIR_FAIL=1; the table is unchanged.
- FAIL_VALID is ignored in IDLE and LOCK.
- Entries fill in order 0,1,2,…; no entry is ever freed before the next clear.
- Lookup: when multiple entries match (impossible given dedup), the lowest index wins.
- REPAIR_FULL = (REPAIR_CNT == SPARE_NUM), registered alongside the count.

## Timing
- Reset (RST=1 at posedge): state IDLE, all valid bits 0, all outputs 0. RST mid-COLLECT discards the table.
- Capture latency: a FAIL_VALID sampled at edge N updates the table at edge N. REPAIR_CNT, REPAIR_FULL and REPAIR_FAIL are visible after edge N.
- Dedup compares against the table contents before edge N. A duplicate on the next cycle (N+1) is therefore correctly discarded.
- Lookup latency is 1 cycle: LKUP_ADDR sampled at edge N gives REMAP_HIT/REMAP_IDX after edge N.
  - REMAP_HIT is forced to 0 unless the state sampled at edge N is LOCK.
- REPAIR_DONE rises 1 cycle after BIST_EN falls and drops 1 cycle after BIST_EN rises.
- Addresses use full ADDR_W equality; there is no masking and no wrap.

## Structure
- Package bisr_pkg holds:
  - State encoding localparams (ST_IDLE=3'b001, ST_COLLECT=3'b010, ST_LOCK=3'b100).
  - Default SPARE_NUM and ADDR_W.
- Sub-module bisr_cam: the SPARE_NUM×ADDR_W entry registers plus valid bits, with two match ports (capture dedup and lookup) and a priority encoder. bisr_repair_alloc holds the FSM, counter, flags and output registers.

## Test plan
- Reset, then BIST_EN=1 with fails 16'h0403, 16'h1C00, 16'h0403, then BIST_EN=0 -> REPAIR_CNT=2, REPAIR_DONE=1 one cycle after BIST_EN drops, REPAIR_FAIL=0.
- After the LOCK above, LKUP_ADDR=16'h1C00 -> next cycle REMAP_HIT=1, REMAP_IDX=1. LKUP_ADDR=16'h1C01 -> REMAP_HIT=0, REMAP_IDX=0.
- SPARE_NUM=8, inject 9 distinct fails back-to-back -> REPAIR_FULL=1 after the 8th, REPAIR_FAIL=1 after the 9th, and a lookup of the 9th address misses in LOCK.
- FAIL_VALID pulses in IDLE and in LOCK -> REPAIR_CNT unchanged. A lookup during COLLECT of a stored address -> REMAP_HIT=0.
- Mid-COLLECT with REPAIR_CNT=3, assert RST for 1 cycle -> all outputs 0 and state IDLE. A new run then refills from entry 0.
- In LOCK with REPAIR_FAIL=1, re-assert BIST_EN -> REPAIR_CNT=0, REPAIR_FAIL=0, REPAIR_DONE=0 after the edge, and old entries no longer hit.
